// File: rtl/audio_i2s_sink.sv
// audio_i2s_sink: mono PCM stream sink that buffers samples in a small FIFO
// and serialises each one to an I2S DAC, duplicated on the left and right slots.
// Optional build macro AUDIO_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_count diagnostic output.
//
// Handshake: a sample is accepted on any posedge where sample_valid is high
// and both ready outputs are high. Ready is simply !fifo_full. A sample offered
// while ready is low is dropped. There is no stall and no error flag.
module audio_i2s_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int BCLK_DIV   = 98
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        left_chan_ready,
  output logic        right_chan_ready,
  output logic        aud_bclk,
  output logic        aud_lrck,
  output logic        aud_sdata,
  output logic        underrun
`ifdef AUDIO_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          div_tc;
  logic          fall_evt;
  logic [4:0]    bit_idx;
  logic [4:0]    next_idx;
  logic          frame_start;
  logic [31:0]   shift_reg;
  logic [31:0]   load_word;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Bit-clock timing and frame event decode
  assign div_tc      = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall_evt    = div_tc & aud_bclk;
  assign next_idx    = bit_idx + 5'd1;
  assign frame_start = fall_evt & (bit_idx == 5'd31);

  // FIFO status; the frame-start pop reads the head before any same-cycle push
  assign full             = (count == CW'(FIFO_DEPTH));
  assign empty            = (count == '0);
  assign left_chan_ready  = ~full;
  assign right_chan_ready = ~full;
  assign push             = sample_valid & ~full;
  assign pop              = frame_start & ~empty;
  assign load_word        = empty ? 32'h0 : {mem[rd_ptr], mem[rd_ptr]};

  // Free-running BCLK divider: toggle aud_bclk every BCLK_DIV clk cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      aud_bclk <= 1'b0;
    end else if (div_tc) begin
      div_cnt  <= '0;
      aud_bclk <= ~aud_bclk;
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser: all data/LRCK updates happen on BCLK falling events
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx   <= 5'd31;
      shift_reg <= 32'h0;
      aud_lrck  <= 1'b0;
      aud_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall_evt) begin
        bit_idx  <= next_idx;
        // LRCK leads each slot MSB by one BCLK (standard I2S)
        aud_lrck <= (next_idx >= 5'd15) && (next_idx <= 5'd30);
        if (frame_start) begin
          aud_sdata <= load_word[31];
          shift_reg <= {load_word[30:0], 1'b0};
          underrun  <= empty;
        end else begin
          aud_sdata <= shift_reg[31];
          shift_reg <= {shift_reg[30:0], 1'b0};
        end
      end
    end
  end

`ifdef AUDIO_UNDERRUN_CNT_EN
  // Saturating count of frames that started with no sample available
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_count <= 16'h0;
    end else if (frame_start && empty && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_i2s_sink.sv
// Testbench for audio_i2s_sink. Runs the DUT with a short BCLK divider so a
// frame is only 2*DIV*32 clk; expected outputs come from a timing model built
// from plain arithmetic on the clk count plus a sample queue.
module tb_audio_i2s_sink;

  localparam int DEPTH     = 4;
  localparam int DIV       = 6;
  localparam int FRAME_CLK = 2 * DIV * 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_data = 16'h0;
  logic        sample_valid = 1'b0;
  logic        left_chan_ready;
  logic        right_chan_ready;
  logic        aud_bclk;
  logic        aud_lrck;
  logic        aud_sdata;
  logic        underrun;
`ifdef AUDIO_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  always #5 clk = ~clk;

  audio_i2s_sink #(.FIFO_DEPTH(DEPTH), .BCLK_DIV(DIV)) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_data      (sample_data),
    .sample_valid     (sample_valid),
    .left_chan_ready  (left_chan_ready),
    .right_chan_ready (right_chan_ready),
    .aud_bclk         (aud_bclk),
    .aud_lrck         (aud_lrck),
    .aud_sdata        (aud_sdata),
    .underrun         (underrun)
`ifdef AUDIO_UNDERRUN_CNT_EN
    ,
    .underrun_count   (underrun_count)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  int          n_clk = 0;
  logic [31:0] cur_word = 32'h0;
  logic        exp_und = 1'b0;
  int          und_cnt = 0;
  bit          start_evt = 1'b0;
  int          und_seen = 0;
  logic [31:0] obs_word = 32'h0;
  logic [31:0] obs_words[$];

  typedef struct {
    logic [15:0] s;
    logic [31:0] w;
  } vec_t;

  function automatic int falls(int n);
    return (n / DIV) / 2;
  endfunction

  function automatic bit is_start(int n);
    return (n > 0) && (falls(n) != falls(n - 1)) && ((falls(n) % 32) == 1);
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each posedge: frame-start pop sees the pre-edge queue, then push
  task automatic model_edge();
    bit was_full;
    if (!reset) begin
      n_clk = 0; exp_q.delete(); cur_word = 32'h0; exp_und = 1'b0;
      und_cnt = 0; start_evt = 1'b0;
      return;
    end
    was_full  = (exp_q.size() == DEPTH);
    n_clk++;
    exp_und   = 1'b0;
    start_evt = is_start(n_clk);
    if (start_evt) begin
      if (exp_q.size() > 0) begin
        cur_word = {exp_q[0], exp_q[0]};
        void'(exp_q.pop_front());
      end else begin
        cur_word = 32'h0;
        exp_und  = 1'b1;
        if (und_cnt < 65535) und_cnt++;
      end
    end
    if (sample_valid && !was_full) exp_q.push_back(sample_data);
  endtask

  task automatic check_outputs();
    int   t, f, p;
    logic e_lr, e_sd;
    t = n_clk / DIV;
    f = t / 2;
    p = 0;
    if (f == 0) begin
      e_lr = 1'b0; e_sd = 1'b0;
    end else begin
      p    = (f - 1) % 32;
      e_lr = (p >= 15) && (p <= 30);
      e_sd = cur_word[31 - p];
    end
    check1("bclk", aud_bclk, t % 2);
    check1("lrck", aud_lrck, e_lr);
    check1("sdata", aud_sdata, e_sd);
    check1("underrun", underrun, exp_und);
    check1("ready_l", left_chan_ready, exp_q.size() < DEPTH);
    check1("ready_r", right_chan_ready, exp_q.size() < DEPTH);
`ifdef AUDIO_UNDERRUN_CNT_EN
    check1("underrun_count", underrun_count, und_cnt);
`endif
    if (underrun) und_seen++;
    if (f > 0 && falls(n_clk) != falls(n_clk - 1)) begin
      obs_word[31 - p] = aud_sdata;
      if (p == 31) obs_words.push_back(obs_word);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic wait_start();
    int b;
    cycle();
    b = 1;
    while (!start_evt && b < 2 * FRAME_CLK) begin
      cycle();
      b++;
    end
    if (!start_evt) check1("wait_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_words(input int k);
    int b;
    b = 0;
    while (obs_words.size() < k && b < (k + 1) * FRAME_CLK) begin
      cycle();
      b++;
    end
    if (obs_words.size() < k) check1("wait_words_timeout", obs_words.size(), k);
  endtask

  task automatic push1(input logic [15:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    cycle();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset(input int k);
    reset = 1'b0;
    run(k);
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[4];
    int   k, b, seen0;
    tbl[0] = '{s: 16'hA5C3, w: 32'hA5C3A5C3};
    tbl[1] = '{s: 16'h8000, w: 32'h80008000};
    tbl[2] = '{s: 16'hFFFF, w: 32'hFFFFFFFF};
    tbl[3] = '{s: 16'h0001, w: 32'h00010001};

    // Reset: values held during reset, first toggle DIV clk after release
    reset = 1'b0;
    @(negedge clk);
    run(5);
    check1("rst_bclk", aud_bclk, 1'b0);
    check1("rst_lrck", aud_lrck, 1'b0);
    check1("rst_sdata", aud_sdata, 1'b0);
    check1("rst_underrun", underrun, 1'b0);
    check1("rst_ready_l", left_chan_ready, 1'b1);
    check1("rst_ready_r", right_chan_ready, 1'b1);
    reset = 1'b1;
    k = 0;
    while (!aud_bclk && k < 4 * DIV) begin
      cycle();
      k++;
    end
    check1("first_bclk_toggle_clks", k, DIV);

    // Table: one sample into an empty FIFO appears in both slots next frame
    for (int i = 0; i < 4; i++) begin
      wait_start();
      obs_words.delete();
      push1(tbl[i].s);
      wait_words(2);
      if (obs_words.size() >= 2) begin
        check1("tbl_prev_frame_zero", obs_words[0], 32'h0);
        check1("tbl_frame_word", obs_words[1], tbl[i].w);
      end
    end

    // Full FIFO: values 1..6 offered back to back, 5 and 6 dropped
    wait_start();
    obs_words.delete();
    for (int v = 1; v <= 6; v++) begin
      sample_data  = 16'(v);
      sample_valid = 1'b1;
      cycle();
      if (v == 3) check1("full_ready_after3", left_chan_ready, 1'b1);
      if (v == 4) check1("full_ready_after4", left_chan_ready, 1'b0);
      if (v == 6) check1("full_ready_after6", right_chan_ready, 1'b0);
    end
    sample_valid = 1'b0;
    wait_words(5);
    if (obs_words.size() >= 5) begin
      check1("full_word1", obs_words[1], 32'h00010001);
      check1("full_word2", obs_words[2], 32'h00020002);
      check1("full_word3", obs_words[3], 32'h00030003);
      check1("full_word4", obs_words[4], 32'h00040004);
    end

    // Simultaneous push and pop at frame start with occupancy 2
    wait_start();
    obs_words.delete();
    push1(16'h1111);
    push1(16'h2222);
    b = 0;
    while (!is_start(n_clk + 1) && b < 2 * FRAME_CLK) begin
      cycle();
      b++;
    end
    sample_data  = 16'h3333;
    sample_valid = 1'b1;
    cycle();
    sample_valid = 1'b0;
    check1("simul_on_start", start_evt, 1'b1);
    check1("simul_ready_l", left_chan_ready, 1'b1);
    check1("simul_ready_r", right_chan_ready, 1'b1);
    wait_words(4);
    if (obs_words.size() >= 4) begin
      check1("simul_word1", obs_words[1], 32'h11111111);
      check1("simul_word2", obs_words[2], 32'h22222222);
      check1("simul_word3", obs_words[3], 32'h33333333);
    end

    // Underrun: three empty frames after a fresh reset
    do_reset(3);
    und_seen = 0;
    wait_start();
    wait_start();
    wait_start();
    check1("underrun_pulses", und_seen, 3);
`ifdef AUDIO_UNDERRUN_CNT_EN
    check1("underrun_count_3", underrun_count, 16'd3);
`endif

    // Mid-frame reset at bit_idx 20 with 3 samples queued
    wait_start();
    push1(16'hBEEF);
    push1(16'hCAFE);
    push1(16'h1234);
    b = 0;
    while (!(falls(n_clk) > 0 && ((falls(n_clk) - 1) % 32) == 20) && b < 2 * FRAME_CLK) begin
      cycle();
      b++;
    end
    check1("midrst_lrck_before", aud_lrck, 1'b1);
    #2 reset = 1'b0;
    #1;
    check1("midrst_bclk", aud_bclk, 1'b0);
    check1("midrst_lrck", aud_lrck, 1'b0);
    check1("midrst_sdata", aud_sdata, 1'b0);
    check1("midrst_underrun", underrun, 1'b0);
    check1("midrst_ready", left_chan_ready, 1'b1);
    run(3);
    reset = 1'b1;
    obs_words.delete();
    seen0 = und_seen;
    wait_words(1);
    if (obs_words.size() >= 1) check1("midrst_first_frame", obs_words[0], 32'h0);
    check1("midrst_underrun_pulse", und_seen - seen0, 1);

    // Random traffic against the model
    for (int i = 0; i < 8 * FRAME_CLK; i++) begin
      sample_valid = ($urandom_range(0, 255) == 0);
      sample_data  = 16'($urandom);
      cycle();
    end
    sample_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
